// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port bundle between the MEM-stage controller (master) and the
// data memory (slave).
interface mem_stage_ctrl_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// LC-3b memory-stage controller: sequences word, byte and indirect accesses
// to data memory and stalls the pipeline while an access is outstanding.
module mem_stage_ctrl (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic                    req_indirect,
  input  logic                    req_byte,
  input  logic [15:0]             req_addr,
  input  logic [15:0]             req_wdata,
  mem_stage_ctrl_if.master        dmem,
  output logic                    mem_stall,
  output logic [15:0]             mdr_out,
  output logic [15:0]             mar_out,
  output logic                    mem_done
);

  typedef enum logic [1:0] {IDLE, IND_RD, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] ptr_q, ptr_d;

  logic        mem_op;
  logic [15:0] ea;
  logic [15:0] rd_data;
  logic [15:0] addr_sel;
  logic [15:0] wdata_sel;
  logic [1:0]  be_sel;
  logic        read_s, write_s, stall_s, done_s;

  always_comb begin
    mem_op    = req_valid & (req_read | req_write);
    ea        = req_indirect ? ptr_q : req_addr;
    rd_data   = req_byte ? {8'h00, (ea[0] ? dmem.dmem_rdata[15:8] : dmem.dmem_rdata[7:0])}
                         : dmem.dmem_rdata;
    addr_sel  = ea;
    be_sel    = 2'b11;
    wdata_sel = req_wdata;
    if (req_byte) begin
      be_sel    = ea[0] ? 2'b10 : 2'b01;
      wdata_sel = {req_wdata[7:0], req_wdata[7:0]};
    end

    state_d = state_q;
    mdr_d   = mdr_q;
    mar_d   = mar_q;
    ptr_d   = ptr_q;
    read_s  = 1'b0;
    write_s = 1'b0;
    stall_s = 1'b0;
    done_s  = 1'b0;

    case (state_q)
      IDLE: begin
        stall_s = mem_op;
        if (mem_op) state_d = req_indirect ? IND_RD : ACCESS;
      end
      IND_RD: begin
        // Pointer fetch is always a full-word read at the instruction's address.
        read_s   = 1'b1;
        stall_s  = 1'b1;
        addr_sel = req_addr;
        be_sel   = 2'b11;
        if (dmem.dmem_resp) begin
          ptr_d   = dmem.dmem_rdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        write_s = req_write;
        read_s  = ~req_write;
        stall_s = 1'b1;
        if (dmem.dmem_resp) begin
          mar_d = ea;
          if (!req_write) mdr_d = rd_data;
          state_d = DONE;
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mdr_q   <= 16'h0000;
      mar_q   <= 16'h0000;
      ptr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      mar_q   <= mar_d;
      ptr_q   <= ptr_d;
    end
  end

  assign dmem.dmem_read        = read_s & ~reset;
  assign dmem.dmem_write       = write_s & ~reset;
  assign dmem.dmem_address     = {addr_sel[15:1], 1'b0};
  assign dmem.dmem_wdata       = wdata_sel;
  assign dmem.dmem_byte_enable = be_sel;
  assign mem_stall             = stall_s & ~reset;
  assign mem_done              = done_s & ~reset;
  assign mdr_out               = mdr_q;
  assign mar_out               = mar_q;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller of the pipelined LC-3b datapath. It sits between the EX/MEM pipeline register and the data-memory port, and produces the MDR/MAR values captured by the MEM/WB register. It sequences word, byte and indirect (LDI/STI) accesses over a request/response handshake. While an access is outstanding it stalls the pipeline, so the MEM/WB load is held low.

Parameters:
None (widths fixed by lc3b_types: lc3b_word = 16 bits).

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  EX/MEM holds a valid instruction
req_read  in  1  instruction reads memory (LDR/LDB/LDI)
req_write  in  1  instruction writes memory (STR/STB/STI)
req_indirect  in  1  LDI/STI: fetch pointer word first
req_byte  in  1  LDB/STB byte access
req_addr  in  16  effective address from EX
req_wdata  in  16  store data from EX
dmem_read  out  1  data-memory read strobe, held until dmem_resp
dmem_write  out  1  data-memory write strobe, held until dmem_resp
dmem_address  out  16  word-aligned address ({addr[15:1],1'b0})
dmem_wdata  out  16  write data
dmem_byte_enable  out  2  byte lanes for writes
dmem_rdata  in  16  read data, valid when dmem_resp=1
dmem_resp  in  1  one-cycle access-complete pulse
mem_stall  out  1  freeze PC/IF/ID/EX/MEM regs; MEM/WB load = ~mem_stall
mdr_out  out  16  to mdr_WB_in
mar_out  out  16  to mar_WB_in: final effective address
mem_done  out  1  one-cycle pulse when the access is complete

Behaviour:
- Reset values (registered): state=IDLE, mdr_out=0, mar_out=0, internal pointer reg=0. While reset=1, dmem_read, dmem_write, mem_stall and mem_done are forced to 0.
- mem_op = req_valid & (req_read | req_write). If both req_read and req_write are set, the access is a write.
- States: IDLE, IND_RD, ACCESS, DONE.
- IDLE:
  - No strobes issued.
  - mem_stall = mem_op (combinational, same cycle).
  - If mem_op & req_indirect, go to IND_RD. Else if mem_op, go to ACCESS. Else stay in IDLE.
  - Non-memory instructions never stall.
- IND_RD:
  - dmem_read=1, address = req_addr word-aligned, mem_stall=1.
  - On dmem_resp: ptr <= dmem_rdata, go to ACCESS.
- ACCESS:
  - ea = req_indirect ? ptr : req_addr.
  - Strobe is dmem_write (if write) else dmem_read; mem_stall=1.
  - On dmem_resp: mar_out <= ea; for reads, mdr_out <= data (below); go to DONE.
  - For writes, mdr_out is unchanged.
- DONE:
  - mem_stall=0, mem_done=1, no strobes, so MEM/WB and upstream load at the end of this cycle.
  - Always go to IDLE. The new EX/MEM contents are evaluated in IDLE on the following cycle; there is no re-issue.
- Byte/word rules:
  - Word access: byte_enable=2'b11, wdata=req_wdata, read data = dmem_rdata. addr[0] is ignored.
  - Byte access: byte_enable = ea[0] ? 2'b10 : 2'b01, wdata = {req_wdata[7:0], req_wdata[7:0]}.
  - Byte read data is zero-extended: ea[0] ? rdata[15:8] : rdata[7:0].
  - Pointer fetch in IND_RD is always a word read.
- Strobes, address, wdata and byte_enable stay stable from the first cycle of a state until dmem_resp. Exactly one strobe is high at a time.
- dmem_resp in IDLE or DONE is ignored; there is no state change and no register update.
- Latency: the minimum stall is 2 cycles (IDLE + ACCESS with immediate resp). Each wait cycle adds 1. Indirect adds 1 + its own wait cycles.
- Reset mid-operation (any state) goes to IDLE next edge. Strobes drop in the reset cycle, and a late dmem_resp after reset is ignored.

Test Plan:
1. Non-memory op: req_valid=1, read=write=0 for 3 cycles -> mem_stall=0 every cycle, no strobes, mem_done=0.
2. LDR word: addr=0x1235, rdata=0xBEEF, resp in 3rd ACCESS cycle -> dmem_address=0x1234, stall high 4 cycles, then DONE with mdr_out=0xBEEF, mar_out=0x1235, mem_done pulse 1 cycle.
3. STB odd address: addr=0x2001, wdata=0x00A5, immediate resp -> dmem_write=1, byte_enable=2'b10, dmem_wdata=0xA5A5, mdr_out unchanged, stall exactly 2 cycles.
4. LDB even/odd: rdata=0x7F80 at addr 0x3000 -> mdr_out=0x0080; at addr 0x3001 -> mdr_out=0x007F.
5. LDI: addr=0x4000, pointer rdata=0x5002, final rdata=0x1234 -> second read at 0x5002, mar_out=0x5002, mdr_out=0x1234, stall 3 cycles with immediate resps.
6. Reset in ACCESS with resp pending -> strobes 0 during the reset cycle, state IDLE. A resp arriving the cycle after reset leaves mdr_out=0 and mar_out=0, and mem_done=0.
